// File: rtl/rx.sv
// UART receiver: oversampled serial input, LSB-first data, stop-bit check,
// ready/read handshake with overrun flag.
// Optional feature macro: RX_PARITY_EN (one parity bit after the data bits).
module rx #(
  parameter int WIDTH_DATA = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  clk_rx,
  input  logic                  i_buf,
  input  logic                  i_re,
  output logic [WIDTH_DATA-1:0] o_data,
  output logic                  o_rdy,
  output logic                  o_ferr,
  output logic                  o_perr,
  output logic                  o_ovr
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (WIDTH_DATA > 1) ? $clog2(WIDTH_DATA) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIDX_LAST = BW'(WIDTH_DATA - 1);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  logic                  r_buf_meta, r_buf_sync;
  logic                  r_clk_meta, r_clk_sync, r_clk_prev;
  logic                  w_tick, w_rx;
  state_t                r_state, w_state_nx;
  logic [CW-1:0]         r_cnt, w_cnt_nx;
  logic [BW-1:0]         r_bidx, w_bidx_nx;
  logic [WIDTH_DATA-1:0] r_sr, w_sr_nx;
  logic                  r_load, w_load_nx;
  logic                  r_stop, w_stop_nx;
  logic [WIDTH_DATA-1:0] r_data;
  logic                  r_rdy, r_ferr, r_ovr;

  // Two-flop synchronizers for the serial line and the oversample clock
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_buf_meta <= 1'b1;
      r_buf_sync <= 1'b1;
      r_clk_meta <= 1'b0;
      r_clk_sync <= 1'b0;
      r_clk_prev <= 1'b0;
    end else begin
      r_buf_meta <= i_buf;
      r_buf_sync <= r_buf_meta;
      r_clk_meta <= clk_rx;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
    end
  end

  assign w_tick = r_clk_sync & ~r_clk_prev;
  assign w_rx   = r_buf_sync;

`ifdef RX_PARITY_EN
  logic r_pbit, w_pbit_nx;
`endif

  // Frame FSM state and datapath registers
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bidx  <= '0;
      r_sr    <= '0;
      r_load  <= 1'b0;
      r_stop  <= 1'b0;
`ifdef RX_PARITY_EN
      r_pbit  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bidx  <= w_bidx_nx;
      r_sr    <= w_sr_nx;
      r_load  <= w_load_nx;
      r_stop  <= w_stop_nx;
`ifdef RX_PARITY_EN
      r_pbit  <= w_pbit_nx;
`endif
    end
  end

  // Next-state logic: start qualification at mid-bit, then sample each bit centre
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bidx_nx  = r_bidx;
    w_sr_nx    = r_sr;
    w_load_nx  = 1'b0;
    w_stop_nx  = r_stop;
`ifdef RX_PARITY_EN
    w_pbit_nx  = r_pbit;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_tick && !w_rx) begin
          w_state_nx = S_START;
          w_cnt_nx   = '0;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_cnt == CNT_HALF) begin
            if (w_rx) begin
              w_state_nx = S_IDLE;
            end else begin
              w_state_nx = S_DATA;
              w_cnt_nx   = '0;
              w_bidx_nx  = '0;
            end
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end else begin
          w_cnt_nx = r_cnt;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_cnt == CNT_LAST) begin
            w_sr_nx  = {w_rx, r_sr[WIDTH_DATA-1:1]};
            w_cnt_nx = '0;
            if (r_bidx == BIDX_LAST) begin
`ifdef RX_PARITY_EN
              w_state_nx = S_PARITY;
`else
              w_state_nx = S_STOP;
`endif
            end else begin
              w_bidx_nx = r_bidx + 1'b1;
            end
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end else begin
          w_cnt_nx = r_cnt;
        end
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          if (r_cnt == CNT_LAST) begin
            w_pbit_nx  = w_rx;
            w_cnt_nx   = '0;
            w_state_nx = S_STOP;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end else begin
          w_cnt_nx = r_cnt;
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          if (r_cnt == CNT_LAST) begin
            w_stop_nx  = w_rx;
            w_load_nx  = 1'b1;
            w_cnt_nx   = '0;
            w_state_nx = w_rx ? S_IDLE : S_BREAK;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end else begin
          w_cnt_nx = r_cnt;
        end
      end
      S_BREAK: begin
        // Line held low past the stop bit: wait for it to return high
        if (w_rx) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_BREAK;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Output register: load a completed frame, or consume it on read; keep old byte on overrun
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_data <= '0;
      r_rdy  <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else if (r_load) begin
      if (r_rdy && !i_re) begin
        r_ovr <= 1'b1;
      end else begin
        r_data <= r_sr;
        r_ferr <= ~r_stop;
        r_rdy  <= 1'b1;
      end
    end else if (i_re && r_rdy) begin
      r_rdy <= 1'b0;
      r_ovr <= 1'b0;
    end
  end

`ifdef RX_PARITY_EN
  logic r_perr;

  // Parity error flag follows the same load/overrun rule as the data byte
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_perr <= 1'b0;
    end else if (r_load && !(r_rdy && !i_re)) begin
      r_perr <= ((^r_sr) ^ r_pbit) != 1'(PARITY_ODD);
    end
  end

  assign o_perr = r_perr;
`else
  assign o_perr = 1'b0;
`endif

  assign o_data = r_data;
  assign o_rdy  = r_rdy;
  assign o_ferr = r_ferr;
  assign o_ovr  = r_ovr;

endmodule

// File: tb/tb_rx.sv
// Self-checking bench for rx: frame-level reference model compared every
// i_clk cycle while outputs are settled, plus literal spot checks.
module tb_rx;
  localparam int W    = 8;
  localparam int OS   = 16;
  localparam int PODD = 0;

  logic         i_clk  = 1'b0;
  logic         i_nrst = 1'b0;
  logic         clk_rx = 1'b0;
  logic         i_buf  = 1'b1;
  logic         i_re   = 1'b0;
  logic [W-1:0] o_data;
  logic         o_rdy, o_ferr, o_perr, o_ovr;

  rx #(.WIDTH_DATA(W), .OVERSAMPLE(OS), .PARITY_ODD(PODD)) dut (
    .i_clk (i_clk),
    .i_nrst(i_nrst),
    .clk_rx(clk_rx),
    .i_buf (i_buf),
    .i_re  (i_re),
    .o_data(o_data),
    .o_rdy (o_rdy),
    .o_ferr(o_ferr),
    .o_perr(o_perr),
    .o_ovr (o_ovr)
  );

  always #5 i_clk = ~i_clk;
  always #20 clk_rx = ~clk_rx;

  int checks = 0;
  int errors = 0;

  // reference model of the visible receiver state
  logic [W-1:0] m_data = '0;
  logic m_rdy = 1'b0, m_ferr = 1'b0, m_perr = 1'b0, m_ovr = 1'b0;
  bit   chk_en = 1'b0;

  time  frame_t0 = 0;
  time  rise_t   = 0;
  time  d_load   = 0;
  logic prev_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // per-cycle comparison of all outputs against the model
  always @(negedge i_clk) begin
    if (chk_en)
      check("cycle {data,rdy,ferr,perr,ovr}", {20'd0, o_data, o_rdy, o_ferr, o_perr, o_ovr},
            {20'd0, m_data, m_rdy, m_ferr, m_perr, m_ovr});
  end

  // record when o_rdy rises (used to place i_re on a load cycle)
  always @(negedge i_clk) begin
    if (o_rdy && !prev_rdy) rise_t = $time;
    prev_rdy = o_rdy;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic good_pbit(input logic [W-1:0] d);
    return (^d) ^ 1'(PODD);
  endfunction

  task automatic model_reset();
    m_data = '0; m_rdy = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
  endtask

  // a completed frame: overrun keeps the old byte unless read in the same cycle
  task automatic model_load(input logic [W-1:0] d, input logic pbit, input logic stop,
                            input logic re_same);
    if (m_rdy && !re_same) begin
      m_ovr = 1'b1;
    end else begin
      m_data = d;
      m_ferr = ~stop;
`ifdef RX_PARITY_EN
      m_perr = ((^d) ^ pbit) != 1'(PODD);
`else
      m_perr = 1'b0;
`endif
      m_rdy  = 1'b1;
    end
  endtask

  task automatic tick_wait(input int n);
    repeat (n) @(posedge clk_rx);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic pbit, input logic stop);
    @(posedge clk_rx);
    frame_t0 = $time;
    i_buf = 1'b0;
    tick_wait(OS);
    for (int i = 0; i < W; i++) begin
      i_buf = d[i];
      tick_wait(OS);
    end
`ifdef RX_PARITY_EN
    i_buf = pbit;
    tick_wait(OS);
`endif
    i_buf = stop;
    tick_wait(OS);
  endtask

  task automatic rx_frame(input logic [W-1:0] d, input logic pbit, input logic stop);
    chk_en = 1'b0;
    send_frame(d, pbit, stop);
    model_load(d, pbit, stop, 1'b0);
    chk_en = 1'b1;
  endtask

  task automatic idle(input int bits);
    i_buf = 1'b1;
    tick_wait(bits * OS);
  endtask

  task automatic do_read();
    @(negedge i_clk);
    chk_en = 1'b0;
    i_re = 1'b1;
    @(negedge i_clk);
    i_re = 1'b0;
    if (m_rdy) begin
      m_rdy = 1'b0;
      m_ovr = 1'b0;
    end
    chk_en = 1'b1;
  endtask

  logic [W-1:0] v;

  initial begin
    // reset state
    repeat (3) @(negedge i_clk);
    check("reset_rdy", o_rdy, 0);
    check("reset_data", o_data, 0);
    check("reset_ovr", o_ovr, 0);
    i_nrst = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // 1: plain frame 0xA5, then read
    rx_frame(8'hA5, good_pbit(8'hA5), 1'b1);
    check("t1_data", o_data, 8'hA5);
    check("t1_rdy", o_rdy, 1);
    check("t1_ferr", o_ferr, 0);
    check("t1_rdy_rise_seen", (rise_t > frame_t0), 1);
    d_load = rise_t - frame_t0;
    idle(1);
    do_read();
    check("t1_read_rdy", o_rdy, 0);

    // 2: short low glitch must not start a frame
    i_buf = 1'b0;
    tick_wait(4);
    idle(3);
    check("t2_rdy", o_rdy, 0);

    // 3: framing error with line held low, then a normal frame
    rx_frame(8'h3C, good_pbit(8'h3C), 1'b0);
    tick_wait(2 * OS);
    idle(2);
    check("t3_data", o_data, 8'h3C);
    check("t3_ferr", o_ferr, 1);
    do_read();
    rx_frame(8'h55, good_pbit(8'h55), 1'b1);
    idle(1);
    check("t3_data2", o_data, 8'h55);
    check("t3_ferr2", o_ferr, 0);

    // 4: overrun
    do_read();
    rx_frame(8'h11, good_pbit(8'h11), 1'b1);
    idle(1);
    rx_frame(8'h22, good_pbit(8'h22), 1'b1);
    idle(1);
    check("t4_data", o_data, 8'h11);
    check("t4_ovr", o_ovr, 1);
    check("t4_rdy", o_rdy, 1);
    do_read();
    check("t4_read_rdy", o_rdy, 0);
    check("t4_read_ovr", o_ovr, 0);

    // 5: read strobe on the load cycle of the second frame
    rx_frame(8'h11, good_pbit(8'h11), 1'b1);
    idle(1);
    chk_en = 1'b0;
    if (d_load < 20) d_load = 20;
    fork
      send_frame(8'h22, good_pbit(8'h22), 1'b1);
      begin
        @(posedge clk_rx);
        #(d_load - 10) i_re = 1'b1;
        #10 i_re = 1'b0;
      end
    join
    model_load(8'h22, good_pbit(8'h22), 1'b1, 1'b1);
    chk_en = 1'b1;
    idle(1);
    check("t5_data", o_data, 8'h22);
    check("t5_rdy", o_rdy, 1);
    check("t5_ovr", o_ovr, 0);

    // 6: reset during data bit 4, then a full frame
    chk_en = 1'b0;
    v = 8'hF0;
    @(posedge clk_rx);
    i_buf = 1'b0;
    tick_wait(OS);
    for (int i = 0; i < 4; i++) begin
      i_buf = v[i];
      tick_wait(OS);
    end
    i_buf = v[4];
    tick_wait(OS / 2);
    i_nrst = 1'b0;
    #1;
    model_reset();
    check("t6_reset_rdy", o_rdy, 0);
    check("t6_reset_data", o_data, 0);
    chk_en = 1'b1;
    repeat (2) @(negedge i_clk);
    i_nrst = 1'b1;
    idle(3);
    rx_frame(8'hF0, good_pbit(8'hF0), 1'b1);
    idle(1);
    check("t6_data", o_data, 8'hF0);
    check("t6_rdy", o_rdy, 1);
    check("t6_ferr", o_ferr, 0);

`ifdef RX_PARITY_EN
    // parity: 0x07 has three ones
    do_read();
    rx_frame(8'h07, 1'b0, 1'b1);
    idle(1);
    check("par_bad", o_perr, 1);
    do_read();
    rx_frame(8'h07, 1'b1, 1'b1);
    idle(1);
    check("par_good", o_perr, 0);
`else
    check("perr_tied", o_perr, 0);
`endif

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
